// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle MIPS sequencing FSM
//
// Purpose: steps each instruction through fetch, decode, execute, memory and
// writeback. The memory read/write steps wait on mem_ready. Unsupported
// opcodes set a sticky flag. Retired instructions are counted.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   en                  run enable, sampled only in FETCH
//   opcode[5:0]         instruction[31:26], sampled only in DECODE
//   mem_ready           memory has completed the current access this cycle
//   pc_write            unconditional PC load
//   pc_write_cond       PC load qualified by the datapath zero flag
//   i_or_d              memory address source (0 = PC, 1 = ALU out register)
//   mem_read, mem_write memory strobes
//   ir_write            instruction register load
//   reg_dst             write register select (1 = rd, 0 = rt)
//   reg_write           register file write enable
//   mem_to_reg          writeback source (1 = memory data)
//   alu_src_a           0 = PC, 1 = read1
//   alu_src_b[1:0]      00 read2, 01 const 4, 10 sign-ext imm, 11 imm << 2
//   alu_op[1:0]         00 add, 01 sub, 10 funct field
//   pc_source[1:0]      00 ALU result, 01 ALU out register, 10 jump target
//   illegal_op          sticky unsupported-opcode flag
//   state[3:0]          current state, for debug
//   retired             retired-instruction count, wraps

module multicycle_controller #(
   parameter int COUNT_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [5:0]             opcode,
   input  logic                   mem_ready,
   output logic                   pc_write,
   output logic                   pc_write_cond,
   output logic                   i_or_d,
   output logic                   mem_read,
   output logic                   mem_write,
   output logic                   ir_write,
   output logic                   reg_dst,
   output logic                   reg_write,
   output logic                   mem_to_reg,
   output logic                   alu_src_a,
   output logic [1:0]             alu_src_b,
   output logic [1:0]             alu_op,
   output logic [1:0]             pc_source,
   output logic                   illegal_op,
   output logic [3:0]             state,
   output logic [COUNT_WIDTH-1:0] retired
);

   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_MEM_ADDR = 4'd2;
   localparam logic [3:0] S_MEM_RD   = 4'd3;
   localparam logic [3:0] S_MEM_WB   = 4'd4;
   localparam logic [3:0] S_MEM_WR   = 4'd5;
   localparam logic [3:0] S_EXEC     = 4'd6;
   localparam logic [3:0] S_R_WB     = 4'd7;
   localparam logic [3:0] S_BRANCH   = 4'd8;
   localparam logic [3:0] S_JUMP     = 4'd9;
   localparam logic [3:0] S_ADDI_EX  = 4'd10;
   localparam logic [3:0] S_ADDI_WB  = 4'd11;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   logic [3:0]             state_q, state_d;
   logic [5:0]             opcode_q, opcode_d;
   logic                   illegal_q, illegal_d;
   logic [COUNT_WIDTH-1:0] retired_q, retired_d;
   logic                   retire;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_FETCH;
         opcode_q  <= '0;
         illegal_q <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         opcode_q  <= opcode_d;
         illegal_q <= illegal_d;
         retired_q <= retired_d;
      end
   end

   // Next-state logic; retire marks the final cycle of a supported instruction
   always_comb begin
      state_d   = state_q;
      opcode_d  = opcode_q;
      illegal_d = illegal_q;
      retire    = 1'b0;
      case (state_q)
         S_FETCH: begin
            if (en && mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            opcode_d = opcode;
            case (opcode)
               OP_RTYPE:     state_d = S_EXEC;
               OP_LW, OP_SW: state_d = S_MEM_ADDR;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               OP_ADDI:      state_d = S_ADDI_EX;
               default: begin
                  state_d   = S_FETCH;
                  illegal_d = 1'b1;
               end
            endcase
         end
         // Only lw and sw reach here, so anything not lw is a store
         S_MEM_ADDR: state_d = (opcode_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD: begin
            if (mem_ready) state_d = S_MEM_WB;
         end
         S_MEM_WR: begin
            if (mem_ready) begin
               state_d = S_FETCH;
               retire  = 1'b1;
            end
         end
         S_EXEC:    state_d = S_R_WB;
         S_ADDI_EX: state_d = S_ADDI_WB;
         S_MEM_WB, S_R_WB, S_ADDI_WB, S_BRANCH, S_JUMP: begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase
      retired_d = retired_q + {{(COUNT_WIDTH-1){1'b0}}, retire};
   end

   // Output decode
   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      mem_to_reg    = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 2'b00;
      case (state_q)
         S_FETCH: begin
            if (en) begin
               mem_read  = 1'b1;
               alu_src_b = 2'b01;
               ir_write  = mem_ready;
               pc_write  = mem_ready;
            end
         end
         S_DECODE: alu_src_b = 2'b11;
         S_MEM_ADDR, S_ADDI_EX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_MEM_RD: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_MEM_WR: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
         end
         S_R_WB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         S_ADDI_WB: reg_write = 1'b1;
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = 2'b01;
            pc_write_cond = 1'b1;
            pc_source     = 2'b01;
         end
         S_JUMP: begin
            pc_write  = 1'b1;
            pc_source = 2'b10;
         end
         default: ;
      endcase
   end

   assign state      = state_q;
   assign illegal_op = illegal_q;
   assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed-vector bench for multicycle_controller
//
// Purpose: drives hand-written instruction sequences into two instances
// (default and 4-bit counter) and checks states, strobes and counters.

module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [5:0] opcode;
   logic       mem_ready;

   logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic        reg_dst, reg_write, mem_to_reg, alu_src_a, illegal_op;
   logic [1:0]  alu_src_b, alu_op, pc_source;
   logic [3:0]  state;
   logic [31:0] retired;

   logic        n_pc_write, n_pc_write_cond, n_i_or_d, n_mem_read, n_mem_write, n_ir_write;
   logic        n_reg_dst, n_reg_write, n_mem_to_reg, n_alu_src_a, n_illegal_op;
   logic [1:0]  n_alu_src_b, n_alu_op, n_pc_source;
   logic [3:0]  n_state;
   logic [3:0]  n_retired;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   multicycle_controller dut (
      .clk(clk), .rst(rst), .en(en), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .reg_dst(reg_dst), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .pc_source(pc_source), .illegal_op(illegal_op), .state(state),
      .retired(retired)
   );

   multicycle_controller #(.COUNT_WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .en(en), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(n_pc_write), .pc_write_cond(n_pc_write_cond), .i_or_d(n_i_or_d),
      .mem_read(n_mem_read), .mem_write(n_mem_write), .ir_write(n_ir_write),
      .reg_dst(n_reg_dst), .reg_write(n_reg_write), .mem_to_reg(n_mem_to_reg),
      .alu_src_a(n_alu_src_a), .alu_src_b(n_alu_src_b), .alu_op(n_alu_op),
      .pc_source(n_pc_source), .illegal_op(n_illegal_op), .state(n_state),
      .retired(n_retired)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Check the current state then advance
   task automatic step(input string tag, input logic [3:0] exp_state);
      check(tag, {28'd0, state}, {28'd0, exp_state});
      tick();
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; opcode = 6'b000000; mem_ready = 1'b1;
      #2;
      check("rst_state", {28'd0, state}, 32'd0);
      check("rst_retired", retired, 32'd0);
      check("rst_illegal", {31'd0, illegal_op}, 32'd0);
      check("rst_fetch_mem_read", {31'd0, mem_read}, 32'd1);
      check("rst_fetch_ir_write", {31'd0, ir_write}, 32'd1);
      check("rst_fetch_alu_src_b", {30'd0, alu_src_b}, 32'd1);
      tick(); tick();
      rst = 1'b0;

      // R-type: 0,1,6,7,0
      check("r_fetch_reg_write", {31'd0, reg_write}, 32'd0);
      step("r_s0", 4'd0);
      step("r_s1", 4'd1);
      check("r_exec_alu_op", {30'd0, alu_op}, 32'd2);
      check("r_exec_reg_write", {31'd0, reg_write}, 32'd0);
      step("r_s2", 4'd6);
      check("r_wb_reg_write", {31'd0, reg_write}, 32'd1);
      check("r_wb_reg_dst", {31'd0, reg_dst}, 32'd1);
      step("r_s3", 4'd7);
      check("r_end_state", {28'd0, state}, 32'd0);
      check("r_retired", retired, 32'd1);

      // lw with two MEM_RD wait cycles; opcode changed after DECODE is ignored
      opcode = 6'b100011;
      step("lw_s0", 4'd0);
      step("lw_s1", 4'd1);
      opcode = 6'b101011;
      check("lw_addr_alu_src_b", {30'd0, alu_src_b}, 32'd2);
      step("lw_s2", 4'd2);
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i == 2) mem_ready = 1'b1;
         #1;
         check("lw_rd_mem_read", {31'd0, mem_read}, 32'd1);
         check("lw_rd_i_or_d", {31'd0, i_or_d}, 32'd1);
         step("lw_rd_state", 4'd3);
      end
      check("lw_wb_reg_write", {31'd0, reg_write}, 32'd1);
      check("lw_wb_mem_to_reg", {31'd0, mem_to_reg}, 32'd1);
      check("lw_wb_reg_dst", {31'd0, reg_dst}, 32'd0);
      step("lw_s6", 4'd4);
      check("lw_end_state", {28'd0, state}, 32'd0);
      check("lw_retired", retired, 32'd2);

      // sw with one FETCH wait cycle
      opcode = 6'b101011;
      mem_ready = 1'b0;
      #1;
      check("sw_fetch_wait_mem_read", {31'd0, mem_read}, 32'd1);
      check("sw_fetch_wait_ir_write", {31'd0, ir_write}, 32'd0);
      check("sw_fetch_wait_pc_write", {31'd0, pc_write}, 32'd0);
      step("sw_wait", 4'd0);
      mem_ready = 1'b1;
      step("sw_s0", 4'd0);
      step("sw_s1", 4'd1);
      step("sw_s2", 4'd2);
      check("sw_wr_mem_write", {31'd0, mem_write}, 32'd1);
      check("sw_wr_reg_write", {31'd0, reg_write}, 32'd0);
      step("sw_s3", 4'd5);
      check("sw_retired", retired, 32'd3);

      // beq
      opcode = 6'b000100;
      step("beq_s0", 4'd0);
      step("beq_s1", 4'd1);
      check("beq_pc_write_cond", {31'd0, pc_write_cond}, 32'd1);
      check("beq_pc_source", {30'd0, pc_source}, 32'd1);
      check("beq_alu_op", {30'd0, alu_op}, 32'd1);
      step("beq_s2", 4'd8);

      // j
      opcode = 6'b000010;
      step("j_s0", 4'd0);
      step("j_s1", 4'd1);
      check("j_pc_write", {31'd0, pc_write}, 32'd1);
      check("j_pc_source", {30'd0, pc_source}, 32'd2);
      step("j_s2", 4'd9);
      check("j_retired", retired, 32'd5);

      // Unsupported opcode, then addi
      opcode = 6'b111111;
      step("ill_s0", 4'd0);
      check("ill_before", {31'd0, illegal_op}, 32'd0);
      step("ill_s1", 4'd1);
      check("ill_after", {31'd0, illegal_op}, 32'd1);
      check("ill_state", {28'd0, state}, 32'd0);
      check("ill_retired", retired, 32'd5);
      opcode = 6'b001000;
      step("addi_s0", 4'd0);
      step("addi_s1", 4'd1);
      check("addi_ex_alu_src_a", {31'd0, alu_src_a}, 32'd1);
      check("addi_ex_alu_src_b", {30'd0, alu_src_b}, 32'd2);
      step("addi_s2", 4'd10);
      check("addi_wb_reg_write", {31'd0, reg_write}, 32'd1);
      check("addi_wb_mem_to_reg", {31'd0, mem_to_reg}, 32'd0);
      step("addi_s3", 4'd11);
      check("addi_retired", retired, 32'd6);
      check("addi_illegal_sticky", {31'd0, illegal_op}, 32'd1);
      check("n_retired_6", {28'd0, n_retired}, 32'd6);

      // en=0 holds FETCH with all strobes low
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("en0_mem_read", {31'd0, mem_read}, 32'd0);
         check("en0_strobes", {29'd0, ir_write, pc_write, alu_src_b != 2'b00}, 32'd0);
         step("en0_state", 4'd0);
      end
      en = 1'b1;

      // lw stalled in MEM_RD, aborted by reset
      opcode = 6'b100011;
      step("abort_s0", 4'd0);
      step("abort_s1", 4'd1);
      step("abort_s2", 4'd2);
      mem_ready = 1'b0;
      step("abort_s3", 4'd3);
      rst = 1'b1;
      #1;
      check("abort_state", {28'd0, state}, 32'd0);
      check("abort_retired", retired, 32'd0);
      check("abort_illegal", {31'd0, illegal_op}, 32'd0);
      check("abort_reg_write", {31'd0, reg_write}, 32'd0);
      mem_ready = 1'b1;
      tick();
      check("abort_hold_reg_write", {31'd0, reg_write}, 32'd0);
      check("abort_hold_mem_write", {31'd0, mem_write}, 32'd0);
      rst = 1'b0;

      // 17 jumps: 4-bit counter wraps to 1
      opcode = 6'b000010;
      for (int i = 0; i < 17; i++) begin
         step("wrap_s0", 4'd0);
         step("wrap_s1", 4'd1);
         step("wrap_s2", 4'd9);
      end
      check("wrap_retired32", retired, 32'd17);
      check("wrap_retired4", {28'd0, n_retired}, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
